mem: RTL and testbench

MEM -- requirements
Module: mem

---
 rtl/mem_if.sv | 25 ++
 rtl/mem.sv | 98 +++++++++
 tb/tb_mem.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Access bus for the mem block: request/enables, sizing, address and data.
// The master drives the access; the slave (the memory) returns rd_data.
interface mem_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     req;
    logic                     wen;
    logic                     ren;
    logic                     zero_ex;
    logic [1:0]               mem_size;
    logic [WIDTH-1:0]         wr_data;
    logic [$clog2(DEPTH)-1:0] addr;
    logic [WIDTH-1:0]         rd_data;

    modport master (
        output req, wen, ren, zero_ex, mem_size, wr_data, addr,
        input  rd_data
    );

    modport slave (
        input  req, wen, ren, zero_ex, mem_size, wr_data, addr,
        output rd_data
    );
endinterface

// File: rtl/mem.sv
// Word-addressed memory with byte/halfword/word writes, sign- or zero-extended
// sub-word reads, and either a registered or a combinational read port.
module mem #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int SYNC_READ = 1
) (
    input  logic clk,
    input  logic res_n,
    mem_if.slave bus
);
    localparam int HALF_W = (WIDTH >= 16) ? 16 : WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             in_range;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rd_fmt;
    logic [WIDTH-1:0] wr_word_d;

    function automatic int size_bits(input logic [1:0] size);
        case (size)
            2'b01:   return 8;
            2'b10:   return HALF_W;
            default: return WIDTH;
        endcase
    endfunction

    // A shift by WIDTH yields 0, so a full-width access gives an all-ones mask.
    function automatic logic [WIDTH-1:0] low_mask(input int bits);
        return (WIDTH'(1) << bits) - WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] fmt_read(input logic [WIDTH-1:0] data,
                                                  input logic [1:0]       size,
                                                  input logic             zero_ex);
        int               bits;
        logic [WIDTH-1:0] m;
        logic             sign;
        bits = size_bits(size);
        m    = low_mask(bits);
        sign = |(data & (WIDTH'(1) << (bits - 1)));
        return (data & m) | ((!zero_ex && sign) ? ~m : '0);
    endfunction

    function automatic logic [WIDTH-1:0] merge_write(input logic [WIDTH-1:0] old,
                                                     input logic [WIDTH-1:0] wd,
                                                     input logic [1:0]       size);
        logic [WIDTH-1:0] m;
        m = low_mask(size_bits(size));
        return (old & ~m) | (wd & m);
    endfunction

    // res_n gates the write enable so a write on a reset edge is discarded.
    always_comb begin
        in_range  = (int'(bus.addr) < DEPTH);
        wr_en     = res_n && bus.req && bus.wen && in_range;
        rd_en     = bus.req && bus.ren;
        rd_word   = in_range ? mem_q[bus.addr] : '0;
        rd_fmt    = fmt_read(rd_word, bus.mem_size, bus.zero_ex);
        wr_word_d = merge_write(rd_word, bus.wr_data, bus.mem_size);
    end

    // Storage is never reset; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.addr] <= wr_word_d;
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [WIDTH-1:0] rd_q;
            logic [WIDTH-1:0] rd_d;

            // rd_fmt comes from pre-edge contents, giving read-before-write.
            always_comb begin
                rd_d = rd_q;
                if (rd_en) begin
                    rd_d = rd_fmt;
                end
            end

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign bus.rd_data = rd_q;
        end else begin : g_comb_read
            assign bus.rd_data = rd_en ? rd_fmt : '0;
        end
    endgenerate
endmodule

// File: tb/tb_mem.sv
// Directed bench for mem: an 8-bit/4-word registered-read instance and a
// 16-bit/3-word combinational-read instance sharing clock and reset.
module tb_mem;
    logic clk = 1'b0;
    logic res_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] shadow [4];

    always #5 clk = ~clk;

    mem_if #(.WIDTH(8),  .DEPTH(4)) b8  ();
    mem_if #(.WIDTH(16), .DEPTH(3)) b16 ();

    mem #(.WIDTH(8), .DEPTH(4), .SYNC_READ(1)) u8 (
        .clk   (clk),
        .res_n (res_n),
        .bus   (b8.slave)
    );

    mem #(.WIDTH(16), .DEPTH(3), .SYNC_READ(0)) u16 (
        .clk   (clk),
        .res_n (res_n),
        .bus   (b16.slave)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr8(input logic [1:0] a, input logic [7:0] d);
        b8.addr = a; b8.wr_data = d; b8.mem_size = 2'b01;
        b8.req = 1'b1; b8.wen = 1'b1; b8.ren = 1'b0;
        @(posedge clk); #1;
        b8.wen = 1'b0;
    endtask

    task automatic rd8(input logic [1:0] a);
        b8.addr = a; b8.mem_size = 2'b01;
        b8.req = 1'b1; b8.ren = 1'b1; b8.wen = 1'b0;
        @(posedge clk); #1;
        b8.ren = 1'b0;
    endtask

    task automatic readall(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd8(2'(i));
            check($sformatf("%s_a%0d", tag, i), 16'(b8.rd_data), 16'(shadow[i]));
        end
    endtask

    task automatic wr16(input logic [1:0] a, input logic [15:0] d, input logic [1:0] size);
        b16.addr = a; b16.wr_data = d; b16.mem_size = size;
        b16.req = 1'b1; b16.wen = 1'b1; b16.ren = 1'b0;
        @(posedge clk); #1;
        b16.wen = 1'b0; b16.req = 1'b0;
    endtask

    task automatic rd16(input logic [1:0] a, input logic [1:0] size, input logic zx);
        b16.addr = a; b16.mem_size = size; b16.zero_ex = zx;
        b16.req = 1'b1; b16.ren = 1'b1; b16.wen = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    initial begin
        res_n = 1'b0;
        b8.req = 0; b8.wen = 0; b8.ren = 0; b8.zero_ex = 0; b8.mem_size = 2'b01;
        b8.wr_data = '0; b8.addr = '0;
        b16.req = 0; b16.wen = 0; b16.ren = 0; b16.zero_ex = 0; b16.mem_size = 2'b00;
        b16.wr_data = '0; b16.addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd", 16'(b8.rd_data), 16'h0000);
        res_n = 1'b1;

        // Stuck-at-1: all zeros
        for (int a = 0; a < 4; a++) begin
            wr8(2'(a), 8'h00);
            shadow[a] = 8'h00;
        end
        readall("zeros");

        // Walking one with full readback
        for (int a = 0; a < 4; a++) begin
            for (int j = 0; j < 8; j++) begin
                wr8(2'(a), 8'h01 << j);
                shadow[a] = 8'h01 << j;
                readall($sformatf("walk_w%0d_b%0d", a, j));
            end
        end

        // Stuck-at-0 / crosstalk
        for (int a = 0; a < 4; a++) begin
            wr8(2'(a), 8'hFF);
            shadow[a] = 8'hFF;
            readall($sformatf("ones_w%0d", a));
        end

        // Logic pattern
        for (int a = 0; a < 4; a++) begin
            wr8(2'(a), 8'(3 - a));
        end
        rd8(2'd0); check("pat_a0", 16'(b8.rd_data), 16'h0003);
        rd8(2'd1); check("pat_a1", 16'(b8.rd_data), 16'h0002);
        rd8(2'd2); check("pat_a2", 16'(b8.rd_data), 16'h0001);
        rd8(2'd3); check("pat_a3", 16'(b8.rd_data), 16'h0000);

        // Read-before-write on the same edge
        b8.addr = 2'd2; b8.wr_data = 8'h5A; b8.req = 1; b8.wen = 1; b8.ren = 1;
        @(posedge clk); #1;
        b8.wen = 0; b8.ren = 0;
        check("rbw_old", 16'(b8.rd_data), 16'h0001);
        rd8(2'd2); check("rbw_new", 16'(b8.rd_data), 16'h005A);

        // req=0 blocks write and freezes rd_data; ren=0 also holds
        b8.req = 0; b8.ren = 1; b8.wen = 1; b8.addr = 2'd0; b8.wr_data = 8'h77;
        @(posedge clk); #1;
        check("hold_noreq", 16'(b8.rd_data), 16'h005A);
        b8.req = 1; b8.ren = 0; b8.wen = 0;
        @(posedge clk); #1;
        check("hold_noren", 16'(b8.rd_data), 16'h005A);
        rd8(2'd0); check("noreq_nowrite", 16'(b8.rd_data), 16'h0003);

        // Async reset clears rd_data, memory survives
        wr8(2'd3, 8'h55);
        rd8(2'd3); check("pre_reset", 16'(b8.rd_data), 16'h0055);
        #1 res_n = 1'b0;
        #1 check("reset_async", 16'(b8.rd_data), 16'h0000);
        #1 res_n = 1'b1;
        rd8(2'd3); check("post_reset", 16'(b8.rd_data), 16'h0055);

        // Write on a reset edge is dropped; first edge after release works
        wr8(2'd1, 8'h11);
        res_n = 1'b0;
        wr8(2'd1, 8'h22);
        check("reset_hold", 16'(b8.rd_data), 16'h0000);
        res_n = 1'b1;
        rd8(2'd1); check("reset_wr_drop", 16'(b8.rd_data), 16'h0011);
        b8.req = 0;

        // 16-bit combinational-read instance: extension and sizes
        wr16(2'd0, 16'h0080, 2'b00);
        rd16(2'd0, 2'b01, 1'b0); check("b_sext", b16.rd_data, 16'hFF80);
        rd16(2'd0, 2'b01, 1'b1); check("b_zext", b16.rd_data, 16'h0080);
        wr16(2'd1, 16'hABCD, 2'b00);
        wr16(2'd1, 16'h3412, 2'b01);
        rd16(2'd1, 2'b00, 1'b0); check("b_wr_merge", b16.rd_data, 16'hAB12);
        rd16(2'd1, 2'b01, 1'b0); check("b_pos_sext", b16.rd_data, 16'h0012);
        wr16(2'd2, 16'h8001, 2'b10);
        rd16(2'd2, 2'b10, 1'b0); check("h_full", b16.rd_data, 16'h8001);
        rd16(2'd2, 2'b11, 1'b0); check("sz11_word", b16.rd_data, 16'h8001);
        wr16(2'd2, 16'h77F5, 2'b01);
        rd16(2'd2, 2'b00, 1'b0); check("b_wr_keep", b16.rd_data, 16'h80F5);
        rd16(2'd2, 2'b01, 1'b0); check("b_sext2", b16.rd_data, 16'hFFF5);
        rd16(2'd2, 2'b01, 1'b1); check("b_zext2", b16.rd_data, 16'h00F5);

        // Out-of-range address
        wr16(2'd3, 16'hDEAD, 2'b00);
        rd16(2'd3, 2'b00, 1'b0); check("oor_read", b16.rd_data, 16'h0000);
        rd16(2'd0, 2'b00, 1'b0); check("oor_nowrite", b16.rd_data, 16'h0080);

        // Combinational read gated by req and ren
        b16.req = 0; #1; check("async_noreq", b16.rd_data, 16'h0000);
        b16.req = 1; b16.ren = 0; #1; check("async_noren", b16.rd_data, 16'h0000);

        // Combinational read shows new data after a write edge
        b16.addr = 2'd0; b16.mem_size = 2'b00; b16.wr_data = 16'h1357;
        b16.req = 1; b16.ren = 1; b16.wen = 1;
        #1 check("async_before", b16.rd_data, 16'h0080);
        @(posedge clk); #1;
        b16.wen = 0;
        check("async_after", b16.rd_data, 16'h1357);
        b16.req = 0; b16.ren = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
